// File: rtl/dhc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dhc_pkg
// Description : Shared definitions for the dhc hex counter: direction-mode
//               codes, the 4-bit count type and the prescaler width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dhc_pkg;

    // Direction-mode codes for the DIR_MODE parameter of dhc_counter
    localparam int DIR_UP     = 0;
    localparam int DIR_DOWN   = 1;
    localparam int DIR_BOUNCE = 2;

    typedef logic [3:0] count_t;

    // Width of the prescaler counter: clog2(DIV), never less than one bit
    function automatic int presc_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage : dhc_pkg
`default_nettype wire

// File: rtl/dhc_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : dhc_prescaler
// Description : Enable-gated clock prescaler. Counts enabled clocks modulo
//               DIV and raises tick on the enabled clock where the count
//               wraps, giving one tick per DIV enabled clocks.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               en    - count enable; when low the phase is frozen
//               tick  - one-cycle step strobe (constantly equal to en for DIV=1)
// Revision    : 1.0 - initial release
// ============================================================================
module dhc_prescaler
    import dhc_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int            c_w    = presc_width(DIV);
    localparam logic [c_w-1:0] c_last = c_w'(DIV - 1);

    generate
        if ((DIV < 1) || (DIV > (1 << 24))) begin : g_bad_div
            $error("dhc_prescaler: DIV must be in 1..2^24");
        end
    endgenerate

    logic [c_w-1:0] r_cnt;
    logic           w_wrap;

    // For DIV=1 the counter sits at 0 == c_last, so every enabled clock ticks
    assign w_wrap = (r_cnt == c_last);
    assign tick   = en && w_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_wrap ? '0 : (r_cnt + c_w'(1));
        end
    end

endmodule : dhc_prescaler
`default_nettype wire

// File: rtl/dhc_counter.sv
`default_nettype none
// ============================================================================
// Module      : dhc_counter
// Description : 4-bit hex counter with built-in prescaler and compile-time
//               direction mode (up, down, bounce). Feeds a seven-segment
//               decoder through dhc_q.
// Ports       : dhc_clk - system clock, rising edge
//               dhc_rst - asynchronous active-low reset
//               dhc_en  - synchronous count enable
//               dhc_q   - registered count value, 0..MAX_VAL
// Macro       : DHC_SATURATE_EN - when defined, up and down modes saturate at
//               their end value instead of wrapping (bounce is unaffected).
// Revision    : 1.0 - initial release
// ============================================================================
module dhc_counter
    import dhc_pkg::*;
#(
    parameter int DIV      = 1,
    parameter int MAX_VAL  = 15,
    parameter int DIR_MODE = 0
) (
    input  logic       dhc_clk,
    input  logic       dhc_rst,
    input  logic       dhc_en,
    output logic [3:0] dhc_q
);

`ifdef DHC_SATURATE_EN
    localparam bit c_saturate = 1'b1;
`else
    localparam bit c_saturate = 1'b0;
`endif

    localparam count_t c_max = count_t'(MAX_VAL);

    generate
        if ((DIR_MODE != DIR_UP) && (DIR_MODE != DIR_DOWN) && (DIR_MODE != DIR_BOUNCE)) begin : g_bad_dir
            $error("dhc_counter: DIR_MODE must be 0 (up), 1 (down) or 2 (bounce)");
        end
        if ((MAX_VAL < 1) || (MAX_VAL > 15)) begin : g_bad_max
            $error("dhc_counter: MAX_VAL must be in 1..15");
        end
    endgenerate

    logic   w_tick;
    count_t r_q;
    logic   r_dir_down;   // bounce direction flag, 0 = counting up
    count_t w_q_next;
    logic   w_dir_down_next;

    dhc_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (dhc_clk),
        .rst_n (dhc_rst),
        .en    (dhc_en),
        .tick  (w_tick)
    );

    // Next count on a step
    always_comb begin
        w_q_next        = r_q;
        w_dir_down_next = r_dir_down;
        if (r_q > c_max) begin
            // Unreachable value (e.g. upset): recover to a known state
            w_q_next        = '0;
            w_dir_down_next = 1'b0;
        end else begin
            case (DIR_MODE)
                DIR_UP: begin
                    if (r_q == c_max) w_q_next = c_saturate ? c_max : '0;
                    else              w_q_next = r_q + count_t'(1);
                end
                DIR_DOWN: begin
                    if (r_q == '0) w_q_next = c_saturate ? '0 : c_max;
                    else           w_q_next = r_q - count_t'(1);
                end
                default: begin
                    // Bounce: flag flips in the same cycle an endpoint is reached,
                    // so endpoints are never repeated.
                    if (!r_dir_down && (r_q != c_max)) begin
                        w_q_next        = r_q + count_t'(1);
                        w_dir_down_next = (w_q_next == c_max);
                    end else if (r_q != '0) begin
                        w_q_next        = r_q - count_t'(1);
                        w_dir_down_next = (w_q_next != '0);
                    end else begin
                        w_q_next        = r_q + count_t'(1);
                        w_dir_down_next = (w_q_next == c_max);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge dhc_clk or negedge dhc_rst) begin
        if (!dhc_rst) begin
            r_q        <= '0;
            r_dir_down <= 1'b0;
        end else if (dhc_en && w_tick) begin
            r_q        <= w_q_next;
            r_dir_down <= w_dir_down_next;
        end
    end

    assign dhc_q = r_q;

endmodule : dhc_counter
`default_nettype wire

// File: tb/tb_dhc_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dhc_counter
// Description : Self-checking bench for dhc_counter. Six instances cover up,
//               down, bounce, prescaled and decade configurations; each is
//               tracked by an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dhc_counter;

`ifdef DHC_SATURATE_EN
    localparam bit c_sat = 1'b1;
`else
    localparam bit c_sat = 1'b0;
`endif

    localparam int c_n = 6;
    // inst:                        up  down bnc3 div4 dec  bnc15/3
    localparam int c_div  [c_n] = '{1,  1,   1,   4,   1,   3};
    localparam int c_max  [c_n] = '{15, 15,  3,   15,  9,   15};
    localparam int c_mode [c_n] = '{0,  1,   2,   0,   0,   2};

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [c_n-1:0] r_en = '1;
    logic [3:0]     w_q [c_n];

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int m_p  [c_n];
    int m_q  [c_n];
    bit m_dn [c_n];

    always #5 clk = ~clk;

    dhc_counter #(.DIV(c_div[0]), .MAX_VAL(c_max[0]), .DIR_MODE(c_mode[0])) u_up
        (.dhc_clk(clk), .dhc_rst(rst_n), .dhc_en(r_en[0]), .dhc_q(w_q[0]));
    dhc_counter #(.DIV(c_div[1]), .MAX_VAL(c_max[1]), .DIR_MODE(c_mode[1])) u_dn
        (.dhc_clk(clk), .dhc_rst(rst_n), .dhc_en(r_en[1]), .dhc_q(w_q[1]));
    dhc_counter #(.DIV(c_div[2]), .MAX_VAL(c_max[2]), .DIR_MODE(c_mode[2])) u_bn3
        (.dhc_clk(clk), .dhc_rst(rst_n), .dhc_en(r_en[2]), .dhc_q(w_q[2]));
    dhc_counter #(.DIV(c_div[3]), .MAX_VAL(c_max[3]), .DIR_MODE(c_mode[3])) u_div4
        (.dhc_clk(clk), .dhc_rst(rst_n), .dhc_en(r_en[3]), .dhc_q(w_q[3]));
    dhc_counter #(.DIV(c_div[4]), .MAX_VAL(c_max[4]), .DIR_MODE(c_mode[4])) u_dec
        (.dhc_clk(clk), .dhc_rst(rst_n), .dhc_en(r_en[4]), .dhc_q(w_q[4]));
    dhc_counter #(.DIV(c_div[5]), .MAX_VAL(c_max[5]), .DIR_MODE(c_mode[5])) u_bn15
        (.dhc_clk(clk), .dhc_rst(rst_n), .dhc_en(r_en[5]), .dhc_q(w_q[5]));

    task automatic model_reset();
        for (int i = 0; i < c_n; i++) begin
            m_p[i]  = 0;
            m_q[i]  = 0;
            m_dn[i] = 1'b0;
        end
    endtask

    // One enabled clock: advance prescaler phase, step the count on every DIV-th.
    task automatic model_edge(input logic [c_n-1:0] en);
        for (int i = 0; i < c_n; i++) begin
            if (en[i]) begin
                m_p[i] = m_p[i] + 1;
                if (m_p[i] == c_div[i]) begin
                    m_p[i] = 0;
                    case (c_mode[i])
                        0: m_q[i] = (m_q[i] == c_max[i]) ? (c_sat ? c_max[i] : 0) : m_q[i] + 1;
                        1: m_q[i] = (m_q[i] == 0) ? (c_sat ? 0 : c_max[i]) : m_q[i] - 1;
                        default: begin
                            m_q[i] = m_dn[i] ? m_q[i] - 1 : m_q[i] + 1;
                            if (m_q[i] == c_max[i]) m_dn[i] = 1'b1;
                            if (m_q[i] == 0)        m_dn[i] = 1'b0;
                        end
                    endcase
                end
            end
        end
    endtask

    // Advance one clock; leaves time at posedge+1 for sampling.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge(r_en);
        #1;
    endtask

    task automatic test_reset();
        r_en  = '1;   // enable held high during reset: reset must win
        rst_n = 1'b0;
        model_reset();
        for (int c = 0; c < 2; c++) begin
            cycle();
            for (int i = 0; i < c_n; i++) begin
                n_vec++;
                if (w_q[i] !== 4'd0) begin
                    n_err++;
                    $display("FAIL reset inst%0d: q=%0d expected 0", i, w_q[i]);
                end
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_count_sequences();
        int exp_end [c_n];
        r_en = '1;
        for (int c = 0; c < 20; c++) begin
            cycle();
            for (int i = 0; i < c_n; i++) begin
                n_vec++;
                if (w_q[i] !== 4'(m_q[i])) begin
                    n_err++;
                    $display("FAIL seq clk%0d inst%0d: q=%0d expected %0d", c, i, w_q[i], m_q[i]);
                end
            end
        end
        // Hand-derived values after 20 enabled clocks from reset
        exp_end[0] = c_sat ? 15 : 4;
        exp_end[1] = c_sat ? 0 : 12;
        exp_end[2] = 2;
        exp_end[3] = 5;
        exp_end[4] = c_sat ? 9 : 0;
        exp_end[5] = 6;
        for (int i = 0; i < c_n; i++) begin
            n_vec++;
            if (w_q[i] !== 4'(exp_end[i])) begin
                n_err++;
                $display("FAIL seq_end inst%0d: q=%0d expected %0d", i, w_q[i], exp_end[i]);
            end
        end
    endtask

    task automatic test_enable_hold();
        for (int c = 0; c < 13; c++) begin
            r_en = (c >= 2 && c < 7) ? '0 : '1;
            cycle();
            for (int i = 0; i < c_n; i++) begin
                n_vec++;
                if (w_q[i] !== 4'(m_q[i])) begin
                    n_err++;
                    $display("FAIL hold clk%0d inst%0d: q=%0d expected %0d", c, i, w_q[i], m_q[i]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        r_en = '1;
        while (m_q[0] != 7 && guard < 40) begin
            cycle();
            guard++;
        end
        n_vec++;
        if (m_q[0] != 7 || w_q[0] !== 4'd7) begin
            n_err++;
            $display("FAIL async_pre: q=%0d expected 7 within 40 clocks", w_q[0]);
        end
        #2;                 // mid-cycle, no clock edge
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < c_n; i++) begin
            n_vec++;
            if (w_q[i] !== 4'd0) begin
                n_err++;
                $display("FAIL async_reset inst%0d: q=%0d expected 0", i, w_q[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            for (int i = 0; i < c_n; i++) begin
                n_vec++;
                if (w_q[i] !== 4'(m_q[i])) begin
                    n_err++;
                    $display("FAIL restart clk%0d inst%0d: q=%0d expected %0d", c, i, w_q[i], m_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            r_en = c_n'($urandom_range(0, (1 << c_n) - 1)) | c_n'($urandom);
            cycle();
            for (int i = 0; i < c_n; i++) begin
                n_vec++;
                if (w_q[i] !== 4'(m_q[i])) begin
                    n_err++;
                    $display("FAIL rand clk%0d inst%0d: q=%0d expected %0d", c, i, w_q[i], m_q[i]);
                end
            end
            if ($urandom_range(0, 49) == 0) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                for (int i = 0; i < c_n; i++) begin
                    n_vec++;
                    if (w_q[i] !== 4'd0) begin
                        n_err++;
                        $display("FAIL rand_reset inst%0d: q=%0d expected 0", i, w_q[i]);
                    end
                end
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_sequences();
        test_enable_hold();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_dhc_counter
`default_nettype wire

// File: doc/dhc_counter.md
Name: dhc_counter

Overview:
- 4-bit hex counter with a built-in clock prescaler and a compile-time direction mode (up, down or bounce).
- Drives a seven-segment decoder stage through dhc_q.
- Single clock domain; counts only when enabled and when the prescaler tick fires.

Parameters:
- DIV, 1, prescaler ratio: one count step per DIV enabled clocks; legal range 1..2^24; 1 means a step on every enabled clock.
- MAX_VAL, 15, terminal count; q ranges 0..MAX_VAL; legal range 1..15 (use 9 for decade operation).
- DIR_MODE, 0, direction: 0 = up, 1 = down, 2 = bounce (ping-pong); other values are illegal and trip an elaboration-time check.

Ports:
- dhc_clk  input  1  system clock; all state updates on the rising edge.
- dhc_rst  input  1  asynchronous, active-low reset.
- dhc_en  input  1  count enable; synchronous, sampled each rising edge.
- dhc_q  output  4  current count value, registered.

Behaviour:
- Reset (dhc_rst=0): asserts immediately, regardless of clock.
  - dhc_q = 0, prescaler count = 0, bounce direction flag = up.
  - Reset is released synchronously-safe: the first update happens on the first rising edge with dhc_rst=1.
- Prescaler:
  - Internal counter of width max(1, clog2(DIV)).
  - When dhc_en=1, it increments each clock; when it equals DIV-1 it wraps to 0 and asserts tick for that cycle.
  - DIV=1: tick is constantly 1 whenever dhc_en=1.
- Enable:
  - dhc_en=0 freezes both the prescaler and dhc_q; no state change.
  - Re-enabling resumes from the frozen state.
- Step: on a rising edge with dhc_en=1 and tick=1, dhc_q updates per mode. Latency is one clock from the tick cycle to the new dhc_q.
- Up mode: q+1; from MAX_VAL wraps to 0.
- Down mode: q-1; from 0 wraps to MAX_VAL. After reset the first step gives MAX_VAL.
- Bounce mode:
  - Flag up: q+1. On reaching MAX_VAL, the flag becomes down in the same cycle.
  - Flag down: q-1. On reaching 0, the flag becomes up.
  - Endpoints are never repeated: ...14,15,14... and ...1,0,1...
- Arithmetic: 4-bit, unsigned. Values above MAX_VAL are unreachable; if one occurs (SEU), the next step forces q to 0.
- Reset mid-count: immediate return to reset values; the prescaler phase is lost.
- Simultaneous reset and enable: reset wins.

Optional Feature:
- Macro: DHC_SATURATE_EN.
- Defined: up and down modes saturate instead of wrapping.
  - Up mode holds at MAX_VAL.
  - Down mode starts from 0 after reset and therefore holds at 0.
  - Bounce mode is unaffected.
- Undefined: wrap-around behaviour as specified in Behaviour.

Decomposition:
- Package dhc_pkg:
  - DIR_UP=0, DIR_DOWN=1, DIR_BOUNCE=2 constants.
  - 4-bit count typedef.
  - Prescaler width function (clog2 with floor of 1).
- Sub-module dhc_prescaler:
  - Parameter DIV.
  - Inputs clk, active-low rst, en; output tick.
- Top dhc_counter: instantiates dhc_prescaler and holds the count/direction logic.

Test Plan:
- Up, DIV=1, MAX_VAL=15: hold dhc_rst=0 for one cycle, then release with dhc_en=1 for 20 clocks -> q = 1,2,...,15,0,1,2,3,4, one step per clock.
- Down, DIV=1: release reset, enable -> q = 15,14,...,0,15; with DHC_SATURATE_EN defined, q stays 0.
- Bounce, MAX_VAL=3: enable 8 clocks -> q = 1,2,3,2,1,0,1,2.
- DIV=4, up: enable 12 clocks -> q steps 0->1->2->3, one step per 4 clocks. Drop dhc_en for 5 clocks -> q and prescaler hold, and the phase resumes on re-enable.
- MAX_VAL=9, up: 11 steps -> 1..9,0,1 (decade wrap). With DHC_SATURATE_EN -> 1..9,9,9.
- Assert dhc_rst=0 between clock edges mid-count (q=7) -> q=0 immediately, without waiting for an edge. Deassert -> counting restarts from 0 on the next enabled tick.
